// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Request/grant/response instruction-memory port.
// Revision : 1.0
// ============================================================================
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : F-stage sequencer: PC register, single-outstanding imem fetch,
//            one-word hold buffer and IF/ID register load.
// Revision : 1.0
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        npc,
    input  logic               stall,
    output logic [31:0]        F_PC,
    output logic               fetch_wait,
    fetch_ctrl_if.master       imem,
    output logic [31:0]        D_Instr,
    output logic [31:0]        D_PC,
    output logic               err
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_f_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic [31:0] r_rbuf;
    logic        r_err;

    logic        w_f_ready;
    logic        w_advance;
    logic [31:0] w_fword;
    logic [31:0] w_npc_aligned;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_protocol_err;

    // Reset gates readiness so nothing advances and fetch_wait stays high.
    assign w_f_ready      = !reset && (((r_state == S_WAIT) && imem.imem_rvalid) ||
                                       (r_state == S_HOLD));
    assign w_advance      = w_f_ready && !stall;
    assign w_fword        = (r_state == S_HOLD) ? r_rbuf : imem.imem_rdata;
    assign w_npc_aligned  = npc & ~32'h0000_0003;
    assign w_protocol_err = imem.imem_rvalid &&
                            ((r_state == S_REQ) || (r_state == S_HOLD));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (imem.imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (stall) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = imem.imem_gnt ? S_WAIT : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_state_nxt = imem.imem_gnt ? S_WAIT : S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Advancing out of WAIT/HOLD issues the successor fetch in the same cycle.
    always_comb begin
        w_req  = 1'b0;
        w_addr = r_f_pc;
        if (!reset) begin
            case (r_state)
                S_REQ: begin
                    w_req = 1'b1;
                end
                S_WAIT, S_HOLD: begin
                    if (w_advance) begin
                        w_req  = 1'b1;
                        w_addr = w_npc_aligned;
                    end
                end
                default: begin
                    w_req = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_pc    <= RESET_PC;
            r_d_instr <= 32'h0000_0000;
            r_d_pc    <= 32'h0000_0000;
            r_rbuf    <= 32'h0000_0000;
            r_err     <= 1'b0;
        end else begin
            if (w_advance) begin
                r_d_instr <= w_fword;
                r_d_pc    <= r_f_pc;
                r_f_pc    <= w_npc_aligned;
            end
            if ((r_state == S_WAIT) && imem.imem_rvalid && stall) begin
                r_rbuf <= imem.imem_rdata;
            end
            if (w_protocol_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;
    assign F_PC           = r_f_pc;
    assign fetch_wait     = !w_f_ready;
    assign D_Instr        = r_d_instr;
    assign D_PC           = r_d_pc;
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Randomized bench for fetch_ctrl against an instruction-stream model.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic [31:0] f_pc;
    logic        fetch_wait;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        err;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(C_RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .F_PC       (f_pc),
        .fetch_wait (fetch_wait),
        .imem       (bus.master),
        .D_Instr    (d_instr),
        .D_PC       (d_pc),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model: fetch PC, IF/ID contents, fetched-word-pending flag.
    logic [31:0] m_fpc, m_dpc, m_dinstr, m_buf;
    logic        m_err, m_need, m_buf_v;
    // Memory slave: one outstanding access with a countdown to its response.
    logic        p_v;
    logic [31:0] p_addr;
    int          p_cnt;
    int          pr_stall, pr_gnt, max_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Program flow: beq at 0x3004 -> 0x3100, jr at 0x310C with misaligned 0x3103.
    function automatic logic [31:0] npc_of(input logic [31:0] fpc, input logic [31:0] dpc);
        if (dpc == 32'h0000_3004) return 32'h0000_3100;
        if (dpc == 32'h0000_310C) return 32'h0000_3103;
        return fpc + 32'd4;
    endfunction

    task automatic model_reset();
        m_fpc    = C_RESET_PC;
        m_dpc    = '0;
        m_dinstr = '0;
        m_buf    = '0;
        m_err    = 1'b0;
        m_need   = 1'b1;
        m_buf_v  = 1'b0;
        p_v      = 1'b0;
        p_cnt    = 0;
    endtask

    task automatic step(input bit rst_in, input bit stray);
        bit          rv_real, f_ready, adv, exp_req, acc;
        logic [31:0] word, exp_addr, nx;
        reset   = rst_in;
        stall   = ($urandom_range(99) < pr_stall);
        bus.imem_gnt = ($urandom_range(99) < pr_gnt) && !stray;
        rv_real = !rst_in && p_v && (p_cnt == 0);
        bus.imem_rvalid = rv_real || stray;
        bus.imem_rdata  = rv_real ? (p_addr ^ C_KEY) : $urandom;
        nx  = npc_of(m_fpc, m_dpc);
        npc = nx;
        #4;
        chk("F_PC", f_pc, m_fpc);
        chk("D_PC", d_pc, m_dpc);
        chk("D_Instr", d_instr, m_dinstr);
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (rst_in) begin
            chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
            chk("rst_fetch_wait", {31'd0, fetch_wait}, 32'd1);
            model_reset();
        end else begin
            f_ready  = rv_real || m_buf_v;
            word     = m_buf_v ? m_buf : bus.imem_rdata;
            adv      = f_ready && !stall;
            exp_req  = m_need || adv;
            exp_addr = m_need ? m_fpc : (nx & ~32'h3);
            chk("fetch_wait", {31'd0, fetch_wait}, {31'd0, !f_ready});
            chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
            if (exp_req) chk("imem_addr", bus.imem_addr, exp_addr);
            acc = exp_req && bus.imem_gnt;
            if (adv) begin
                m_dpc    = m_fpc;
                m_dinstr = word;
                m_fpc    = nx & ~32'h3;
                m_buf_v  = 1'b0;
                m_need   = !bus.imem_gnt;
            end else if (rv_real) begin
                m_buf_v = 1'b1;
                m_buf   = bus.imem_rdata;
            end else if (m_need && bus.imem_gnt) begin
                m_need = 1'b0;
            end
            if (stray) m_err = 1'b1;
            if (rv_real) p_v = 1'b0;
            else if (p_v) p_cnt--;
            if (acc) begin
                p_v    = 1'b1;
                p_addr = exp_addr;
                p_cnt  = $urandom_range(max_d - 1, 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        npc   = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        pr_stall = 0;
        pr_gnt   = 100;
        max_d    = 1;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0);

        // Ideal memory: one instruction per cycle after the first fetch.
        for (int i = 0; i < 40; i++) step(0, 0);

        for (int r = 0; r < 4; r++) begin
            int n;
            pr_stall = $urandom_range(50, 10);
            pr_gnt   = $urandom_range(90, 30);
            max_d    = $urandom_range(4, 1);
            for (int i = 0; i < 300; i++) step(0, 0);
            // Reset with an access in flight, then a stray response.
            n = 0;
            while (!p_v && n < 50) begin
                step(0, 0);
                n++;
            end
            chk("reach_wait", {31'd0, p_v}, 32'd1);
            step(1, 0);
            step(0, 1);
            for (int i = 0; i < 20; i++) step(0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
